// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
//
// Owns the single write port of the tile framebuffer memory controller.
// Two cell writers share the port: port 0 (game graphics) and port 1
// (overlay/score). A built-in clear engine fills every cell with one colour.
// When BLANK_ONLY is set, writes are issued only during vertical blanking
// (vc >= V_VISIBLE), so the displayed frame never tears.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   vc                       vertical counter from the VGA timing block
//   clear_start/clear_color  start a full-buffer clear with the given colour
//   reqN/addrN/dataN         writer N request; held stable until gntN
//   gntN                     one-cycle grant, coincides with the issued write
//   wr_en/wr_addr/wr_data    write port of the memory controller
//   clearing                 clear engine owns the write port
//   clear_done               one-cycle pulse after the last clear write
//
// All outputs are registered. A grant decided on an edge is visible in the
// following cycle together with the write it carries.

module fb_write_arbiter #(
    parameter int CELLS      = 768,
    parameter int ADDR_W     = 10,
    parameter int V_VISIBLE  = 480,
    parameter int BLANK_ONLY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        vc,
    input  logic              clear_start,
    input  logic [7:0]        clear_color,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [7:0]        data0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [7:0]        data1,
    output logic              gnt1,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              clearing,
    output logic              clear_done
);

    localparam logic [9:0]        V_VIS     = 10'(V_VISIBLE);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

    // FINISH is the cycle in which the last clear write is visible; the
    // clear_done pulse is produced on the edge that leaves it.
    typedef enum logic [1:0] {
        RUN,
        CLEAR,
        FINISH
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   cnt_reg, cnt_next;
    logic [7:0]          color_reg, color_next;
    logic                ptr_reg, ptr_next;      // port favoured on a tie
    logic [1:0]          gnt_reg, gnt_next;
    logic                wr_en_reg, wr_en_next;
    logic [ADDR_W-1:0]   wr_addr_reg, wr_addr_next;
    logic [7:0]          wr_data_reg, wr_data_next;
    logic                clearing_reg, clearing_next;
    logic                done_reg, done_next;

    logic                win;
    logic [1:0]          req_vec;
    logic [1:0]          elig;
    logic                pick1;

    assign win     = (BLANK_ONLY == 0) || (vc >= V_VIS);
    assign req_vec = {req1, req0};

    // A port whose grant is showing this cycle has its request ignored, so
    // the held request that was just served cannot be granted twice.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_elig
            assign elig[gi] = req_vec[gi] & ~gnt_reg[gi];
        end
    endgenerate

    assign pick1 = elig[1] & (~elig[0] | ptr_reg);

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        color_next    = color_reg;
        ptr_next      = ptr_reg;
        gnt_next      = 2'b00;
        wr_en_next    = 1'b0;
        wr_addr_next  = wr_addr_reg;
        wr_data_next  = wr_data_reg;
        clearing_next = clearing_reg;
        done_next     = 1'b0;

        case (state_reg)
            RUN: begin
                if (clear_start) begin
                    state_next    = CLEAR;
                    cnt_next      = '0;
                    color_next    = clear_color;
                    clearing_next = 1'b1;
                end else if (win && (elig != 2'b00)) begin
                    wr_en_next = 1'b1;
                    if (pick1) begin
                        gnt_next     = 2'b10;
                        wr_addr_next = addr1;
                        wr_data_next = data1;
                        ptr_next     = 1'b0;
                    end else begin
                        gnt_next     = 2'b01;
                        wr_addr_next = addr0;
                        wr_data_next = data0;
                        ptr_next     = 1'b1;
                    end
                end
            end

            CLEAR: begin
                // Outside the window the counter simply stalls.
                if (win) begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = cnt_reg;
                    wr_data_next = color_reg;
                    if (cnt_reg == LAST_CELL) begin
                        cnt_next   = '0;
                        state_next = FINISH;
                    end else begin
                        cnt_next = cnt_reg + ADDR_W'(1);
                    end
                end
            end

            FINISH: begin
                clearing_next = 1'b0;
                done_next     = 1'b1;
                state_next    = RUN;
            end

            default: begin
                state_next    = RUN;
                clearing_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= RUN;
            cnt_reg      <= '0;
            color_reg    <= '0;
            ptr_reg      <= 1'b0;
            gnt_reg      <= 2'b00;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            clearing_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            color_reg    <= color_next;
            ptr_reg      <= ptr_next;
            gnt_reg      <= gnt_next;
            wr_en_reg    <= wr_en_next;
            wr_addr_reg  <= wr_addr_next;
            wr_data_reg  <= wr_data_next;
            clearing_reg <= clearing_next;
            done_reg     <= done_next;
        end
    end

    assign gnt0       = gnt_reg[0];
    assign gnt1       = gnt_reg[1];
    assign wr_en      = wr_en_reg;
    assign wr_addr    = wr_addr_reg;
    assign wr_data    = wr_data_reg;
    assign clearing   = clearing_reg;
    assign clear_done = done_reg;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Testbench for fb_write_arbiter. Two instances run side by side:
// instance 0 with BLANK_ONLY=0 (always writable) and instance 1 with
// BLANK_ONLY=1 (writes only while vc >= 480). Each has its own stimulus and
// its own reference model; every cycle all outputs are compared.

module tb_fb_write_arbiter;

    localparam int NCELL = 768;

    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    // Stimulus, indexed [instance] or [instance][port]
    logic [9:0] vc          [2];
    logic       clear_start [2];
    logic [7:0] clear_color [2];
    logic       r_req       [2][2];
    logic [9:0] r_addr      [2][2];
    logic [7:0] r_data      [2][2];

    // Observed DUT outputs
    logic       gnt0_dut     [2];
    logic       gnt1_dut     [2];
    logic       wr_en_dut    [2];
    logic [9:0] wr_addr_dut  [2];
    logic [7:0] wr_data_dut  [2];
    logic       clearing_dut [2];
    logic       done_dut     [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        fb_write_arbiter #(
            .CELLS      (NCELL),
            .ADDR_W     (10),
            .V_VISIBLE  (480),
            .BLANK_ONLY (gi)
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .vc          (vc[gi]),
            .clear_start (clear_start[gi]),
            .clear_color (clear_color[gi]),
            .req0        (r_req[gi][0]),
            .addr0       (r_addr[gi][0]),
            .data0       (r_data[gi][0]),
            .gnt0        (gnt0_dut[gi]),
            .req1        (r_req[gi][1]),
            .addr1       (r_addr[gi][1]),
            .data1       (r_data[gi][1]),
            .gnt1        (gnt1_dut[gi]),
            .wr_en       (wr_en_dut[gi]),
            .wr_addr     (wr_addr_dut[gi]),
            .wr_data     (wr_data_dut[gi]),
            .clearing    (clearing_dut[gi]),
            .clear_done  (done_dut[gi])
        );
    end

    int n_checks = 0;
    int n_errors = 0;
    bit vc_run   = 1'b0;
    bit auto_req = 1'b0;

    // Reference model: clear progress as "next address to write" plus a
    // pending-done flag; arbitration as "port favoured on a tie".
    bit         e_gnt       [2][2];
    bit         e_wr_en     [2];
    logic [9:0] e_wr_addr   [2];
    logic [7:0] e_wr_data   [2];
    bit         e_clearing  [2];
    bit         e_done      [2];
    int         m_favour    [2];
    bit         m_clr_active[2];
    bit         m_clr_tail  [2];
    int         m_clr_next  [2];
    logic [7:0] m_clr_color [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int n);
        e_gnt[n][0]     = 1'b0;
        e_gnt[n][1]     = 1'b0;
        e_wr_en[n]      = 1'b0;
        e_wr_addr[n]    = '0;
        e_wr_data[n]    = '0;
        e_clearing[n]   = 1'b0;
        e_done[n]       = 1'b0;
        m_favour[n]     = 0;
        m_clr_active[n] = 1'b0;
        m_clr_tail[n]   = 1'b0;
        m_clr_next[n]   = 0;
        m_clr_color[n]  = '0;
    endtask

    task automatic model_step(input int n);
        bit win;
        bit elig [2];
        bit ng   [2];
        bit nwe;
        bit ndone;
        bit ncl;
        int cand;
        win   = (n == 0) || (vc[n] >= 10'd480);
        ng[0] = 1'b0;
        ng[1] = 1'b0;
        nwe   = 1'b0;
        ndone = 1'b0;
        ncl   = e_clearing[n];
        for (int p = 0; p < 2; p++) elig[p] = r_req[n][p] && !e_gnt[n][p];
        if (m_clr_tail[n]) begin
            m_clr_tail[n]   = 1'b0;
            m_clr_active[n] = 1'b0;
            ncl             = 1'b0;
            ndone           = 1'b1;
        end else if (m_clr_active[n]) begin
            if (win) begin
                nwe           = 1'b1;
                e_wr_addr[n]  = 10'(m_clr_next[n]);
                e_wr_data[n]  = m_clr_color[n];
                m_clr_next[n] = m_clr_next[n] + 1;
                if (m_clr_next[n] == NCELL) m_clr_tail[n] = 1'b1;
            end
        end else if (clear_start[n]) begin
            m_clr_active[n] = 1'b1;
            m_clr_next[n]   = 0;
            m_clr_color[n]  = clear_color[n];
            ncl             = 1'b1;
        end else if (win) begin
            cand = -1;
            if (elig[0] && elig[1]) cand = m_favour[n];
            else if (elig[0])       cand = 0;
            else if (elig[1])       cand = 1;
            if (cand >= 0) begin
                ng[cand]     = 1'b1;
                nwe          = 1'b1;
                e_wr_addr[n] = r_addr[n][cand];
                e_wr_data[n] = r_data[n][cand];
                m_favour[n]  = 1 - cand;
            end
        end
        e_gnt[n][0]   = ng[0];
        e_gnt[n][1]   = ng[1];
        e_wr_en[n]    = nwe;
        e_done[n]     = ndone;
        e_clearing[n] = ncl;
    endtask

    task automatic compare_all();
        for (int n = 0; n < 2; n++) begin
            check($sformatf("i%0d gnt0", n),       32'(gnt0_dut[n]),     32'(e_gnt[n][0]));
            check($sformatf("i%0d gnt1", n),       32'(gnt1_dut[n]),     32'(e_gnt[n][1]));
            check($sformatf("i%0d wr_en", n),      32'(wr_en_dut[n]),    32'(e_wr_en[n]));
            check($sformatf("i%0d wr_addr", n),    32'(wr_addr_dut[n]),  32'(e_wr_addr[n]));
            check($sformatf("i%0d wr_data", n),    32'(wr_data_dut[n]),  32'(e_wr_data[n]));
            check($sformatf("i%0d clearing", n),   32'(clearing_dut[n]), 32'(e_clearing[n]));
            check($sformatf("i%0d clear_done", n), 32'(done_dut[n]),     32'(e_done[n]));
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int n = 0; n < 2; n++) begin
            check($sformatf("%s i%0d gnt0", tag, n),       32'(gnt0_dut[n]),     32'd0);
            check($sformatf("%s i%0d gnt1", tag, n),       32'(gnt1_dut[n]),     32'd0);
            check($sformatf("%s i%0d wr_en", tag, n),      32'(wr_en_dut[n]),    32'd0);
            check($sformatf("%s i%0d wr_addr", tag, n),    32'(wr_addr_dut[n]),  32'd0);
            check($sformatf("%s i%0d wr_data", tag, n),    32'(wr_data_dut[n]),  32'd0);
            check($sformatf("%s i%0d clearing", tag, n),   32'(clearing_dut[n]), 32'd0);
            check($sformatf("%s i%0d clear_done", tag, n), 32'(done_dut[n]),     32'd0);
        end
    endtask

    // One clock: model update on the edge, compare 1 ns later, then drive
    // the inputs for the next edge.
    task automatic cycle();
        @(posedge clk);
        if (!rst) for (int n = 0; n < 2; n++) model_step(n);
        #1;
        compare_all();
        for (int n = 0; n < 2; n++) begin
            clear_start[n] = 1'b0;
            if (vc_run) vc[n] = (vc[n] >= 10'd524) ? 10'd0 : vc[n] + 10'd1;
            if (auto_req) begin
                for (int p = 0; p < 2; p++) begin
                    if (r_req[n][p]) begin
                        if (e_gnt[n][p]) begin
                            if ($urandom_range(1) == 1) begin
                                r_addr[n][p] = 10'($urandom_range(1023));
                                r_data[n][p] = 8'($urandom_range(255));
                            end else begin
                                r_req[n][p] = 1'b0;
                            end
                        end
                    end else if ($urandom_range(2) == 0) begin
                        r_req[n][p]  = 1'b1;
                        r_addr[n][p] = 10'($urandom_range(1023));
                        r_data[n][p] = 8'($urandom_range(255));
                    end
                end
                if ($urandom_range(1499) == 0) begin
                    clear_start[n] = 1'b1;
                    clear_color[n] = 8'($urandom_range(255));
                end
            end
        end
    endtask

    task automatic drop_requests();
        for (int n = 0; n < 2; n++)
            for (int p = 0; p < 2; p++) r_req[n][p] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        int  last;
        int  gp;
        int  g_cnt;
        int  writes    [2];
        bit  done_seen [2];
        bit  gnt_seen  [2];

        rst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            vc[n]          = '0;
            clear_start[n] = 1'b0;
            clear_color[n] = '0;
            for (int p = 0; p < 2; p++) begin
                r_req[n][p]  = 1'b0;
                r_addr[n][p] = '0;
                r_data[n][p] = '0;
            end
            model_reset(n);
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        $display("phase reset: checks=%0d errors=%0d", n_checks, n_errors);

        // Randomized traffic with occasional clears, vc sweeping the frame
        vc_run   = 1'b1;
        auto_req = 1'b1;
        repeat (3000) cycle();
        auto_req = 1'b0;
        drop_requests();
        k = 0;
        while ((m_clr_active[0] || m_clr_tail[0] || m_clr_active[1] || m_clr_tail[1]) && k < 30000) begin
            cycle();
            k++;
        end
        check("idle wait timeout", 32'(k < 30000), 32'd1);
        repeat (2) cycle();
        $display("phase random traffic: checks=%0d errors=%0d", n_checks, n_errors);

        // Contention: both ports held on the always-writable instance
        for (int n = 0; n < 2; n++) begin
            r_req[n][0] = 1'b1;  r_addr[n][0] = 10'd10;  r_data[n][0] = 8'h11;
            r_req[n][1] = 1'b1;  r_addr[n][1] = 10'd20;  r_data[n][1] = 8'h22;
        end
        last  = -1;
        g_cnt = 0;
        repeat (40) begin
            cycle();
            check("contention overlap", 32'(gnt0_dut[0] & gnt1_dut[0]), 32'd0);
            if (gnt0_dut[0] || gnt1_dut[0]) begin
                gp = gnt1_dut[0] ? 1 : 0;
                if (last >= 0) check("contention alternate", 32'(gp), 32'(1 - last));
                last = gp;
                g_cnt++;
            end
        end
        check("contention grant count", 32'(g_cnt), 32'd40);
        drop_requests();
        repeat (3) cycle();
        $display("phase contention: checks=%0d errors=%0d", n_checks, n_errors);

        // Window gating on the blanking-only instance
        vc_run = 1'b0;
        vc[0]  = 10'd100;
        vc[1]  = 10'd100;
        r_req[1][1] = 1'b1;  r_addr[1][1] = 10'h155;  r_data[1][1] = 8'h5A;
        repeat (8) begin
            cycle();
            check("gate no write", 32'(wr_en_dut[1]), 32'd0);
        end
        vc[0] = 10'd480;
        vc[1] = 10'd480;
        cycle();
        check("gate gnt1",    32'(gnt1_dut[1]),    32'd1);
        check("gate wr_en",   32'(wr_en_dut[1]),   32'd1);
        check("gate wr_addr", 32'(wr_addr_dut[1]), 32'h155);
        check("gate wr_data", 32'(wr_data_dut[1]), 32'h5A);
        r_req[1][1] = 1'b0;
        repeat (2) cycle();
        $display("phase window gating: checks=%0d errors=%0d", n_checks, n_errors);

        // Full clear from vc=470, with a held request and a re-pulse mid-clear
        vc_run = 1'b1;
        for (int n = 0; n < 2; n++) begin
            vc[n]          = 10'd470;
            clear_start[n] = 1'b1;
            clear_color[n] = 8'h03;
            writes[n]      = 0;
            done_seen[n]   = 1'b0;
            gnt_seen[n]    = 1'b0;
        end
        cycle();
        k = 0;
        while (!(done_seen[0] && done_seen[1] && gnt_seen[0] && gnt_seen[1]) && k < 25000) begin
            if (k == 300) begin
                for (int n = 0; n < 2; n++) begin
                    r_req[n][0]    = 1'b1;
                    r_addr[n][0]   = 10'h2A;
                    r_data[n][0]   = 8'hC3;
                    clear_start[n] = 1'b1;
                    clear_color[n] = 8'hFF;
                end
            end
            cycle();
            k++;
            for (int n = 0; n < 2; n++) begin
                if (wr_en_dut[n] && clearing_dut[n]) writes[n]++;
                if (clearing_dut[n] || done_dut[n])
                    check($sformatf("i%0d gnt0 during clear", n), 32'(gnt0_dut[n]), 32'd0);
                if (done_dut[n]) begin
                    done_seen[n] = 1'b1;
                    check($sformatf("i%0d clear write count", n), 32'(writes[n]), 32'(NCELL));
                end
                if (gnt0_dut[n] && k > 300) begin
                    gnt_seen[n] = 1'b1;
                    check($sformatf("i%0d held gnt after done", n), 32'(done_seen[n]), 32'd1);
                    check($sformatf("i%0d held wr_addr", n), 32'(wr_addr_dut[n]), 32'h2A);
                    check($sformatf("i%0d held wr_data", n), 32'(wr_data_dut[n]), 32'hC3);
                    r_req[n][0] = 1'b0;
                end
            end
        end
        for (int n = 0; n < 2; n++)
            check($sformatf("i%0d clear completion", n), 32'(done_seen[n] && gnt_seen[n]), 32'd1);
        drop_requests();
        repeat (2) cycle();
        $display("phase full clear: checks=%0d errors=%0d", n_checks, n_errors);

        // Asynchronous reset in the middle of a clear
        vc_run = 1'b0;
        for (int n = 0; n < 2; n++) begin
            vc[n]          = 10'd480;
            clear_start[n] = 1'b1;
            clear_color[n] = 8'h7C;
        end
        cycle();
        k = 0;
        while (m_clr_next[0] != 300 && k < 1000) begin
            cycle();
            k++;
        end
        check("midclear last addr", 32'(wr_addr_dut[0]), 32'd299);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async reset");
        for (int n = 0; n < 2; n++) model_reset(n);
        cycle();
        rst = 1'b0;
        for (int n = 0; n < 2; n++) begin
            r_req[n][0]  = 1'b1;
            r_addr[n][0] = 10'd5;
            r_data[n][0] = 8'hE0;
        end
        cycle();
        for (int n = 0; n < 2; n++) begin
            check($sformatf("i%0d post-reset gnt0", n),    32'(gnt0_dut[n]),    32'd1);
            check($sformatf("i%0d post-reset wr_en", n),   32'(wr_en_dut[n]),   32'd1);
            check($sformatf("i%0d post-reset wr_addr", n), 32'(wr_addr_dut[n]), 32'd5);
            check($sformatf("i%0d post-reset wr_data", n), 32'(wr_data_dut[n]), 32'hE0);
        end
        drop_requests();
        repeat (2) cycle();
        $display("phase reset mid-clear: checks=%0d errors=%0d", n_checks, n_errors);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
